// File: rtl/seg7_pkg.sv
// Shared constants, types and width helper for the seven-segment scan controller.
package seg7_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Active-low g..a patterns, index F down to 0.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    typedef enum logic {
        StBlank,
        StDrive
    } scan_state_e;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to active-low seven-segment pattern lookup.
module seg_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_n_o
);

    always_comb begin
        seg_n_o = HEX_SEG[nib_i];
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed common-anode seven-segment scan controller with double-buffered
// value, per-digit enable, leading-zero blanking and an inter-digit blanking guard.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned REFRESH_DIV  = 50000,
    parameter int unsigned BLANK_CYCLES = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] value_i,
    input  logic [NUM_DIGITS-1:0]   dp_i,
    input  logic [NUM_DIGITS-1:0]   digit_en_i,
    input  logic                    lz_suppress_i,
    input  logic                    load_i,
    output logic [7:0]              seg_n_o,
    output logic [NUM_DIGITS-1:0]   an_n_o,
    output logic                    frame_done_o
);

    localparam int unsigned CntW = cnt_width(REFRESH_DIV);
    localparam int unsigned IdxW = cnt_width(NUM_DIGITS);

    localparam logic [CntW-1:0] CntLast  = CntW'(REFRESH_DIV - 1);
    localparam logic [CntW-1:0] BlankEnd = CntW'(BLANK_CYCLES);
    localparam logic [IdxW-1:0] IdxLast  = IdxW'(NUM_DIGITS - 1);

    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [IdxW-1:0]         idx_q, idx_d;
    scan_state_e             state_q, state_d;
    logic [4*NUM_DIGITS-1:0] pend_val_q, pend_val_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic [4*NUM_DIGITS-1:0] act_val_q, act_val_d;
    logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d;
    logic [7:0]              seg_n_q, seg_n_d;
    logic [NUM_DIGITS-1:0]   an_n_q, an_n_d;
    logic                    frame_done_q, frame_done_d;

    logic       slot_wrap;
    logic       frame_wrap;
    logic [3:0] nib_sel;
    logic       dp_sel;
    logic       en_sel;
    logic       zero_lead;
    logic       lit;
    logic [6:0] seg_hex_n;

    // Slot counter and digit index
    always_comb begin
        slot_wrap  = (cnt_q == CntLast);
        frame_wrap = slot_wrap && (idx_q == IdxLast);
        cnt_d      = slot_wrap ? '0 : cnt_q + 1'b1;
        idx_d      = idx_q;
        if (frame_wrap) begin
            idx_d = '0;
        end else if (slot_wrap) begin
            idx_d = idx_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StBlank: if (cnt_d == BlankEnd) state_d = StDrive;
            StDrive: if (slot_wrap)         state_d = StBlank;
            default:                        state_d = StBlank;
        endcase
    end

    // Commit takes the pending value as it stood before this edge, so a load on the
    // wrap edge lands one frame later.
    always_comb begin
        pend_val_d = load_i ? value_i : pend_val_q;
        pend_dp_d  = load_i ? dp_i    : pend_dp_q;
        act_val_d  = frame_wrap ? pend_val_q : act_val_q;
        act_dp_d   = frame_wrap ? pend_dp_q  : act_dp_q;
    end

    // Outputs are computed from next-state values so the registered pins line up with cnt.
    always_comb begin
        nib_sel   = 4'h0;
        dp_sel    = 1'b0;
        en_sel    = 1'b0;
        zero_lead = lz_suppress_i && (idx_d != '0);
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if (IdxW'(j) == idx_d) begin
                nib_sel = act_val_d[4*j +: 4];
                dp_sel  = act_dp_d[j];
                en_sel  = digit_en_i[j];
            end
            if ((IdxW'(j) >= idx_d) && (act_val_d[4*j +: 4] != 4'h0)) begin
                zero_lead = 1'b0;
            end
        end
    end

    seg_hex_decode u_hex_decode (
        .nib_i   (nib_sel),
        .seg_n_o (seg_hex_n)
    );

    always_comb begin
        lit          = (state_d == StDrive) && en_sel && !zero_lead;
        seg_n_d      = SEG_BLANK;
        an_n_d       = '1;
        frame_done_d = frame_wrap;
        if (lit) begin
            seg_n_d = {~dp_sel, seg_hex_n};
            for (int j = 0; j < NUM_DIGITS; j++) begin
                an_n_d[j] = (IdxW'(j) != idx_d);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            state_q      <= StBlank;
            pend_val_q   <= '0;
            pend_dp_q    <= '0;
            act_val_q    <= '0;
            act_dp_q     <= '0;
            seg_n_q      <= SEG_BLANK;
            an_n_q       <= '1;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            state_q      <= state_d;
            pend_val_q   <= pend_val_d;
            pend_dp_q    <= pend_dp_d;
            act_val_q    <= act_val_d;
            act_dp_q     <= act_dp_d;
            seg_n_q      <= seg_n_d;
            an_n_q       <= an_n_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg_n_o      = seg_n_q;
    assign an_n_o       = an_n_q;
    assign frame_done_o = frame_done_q;

endmodule
